// File: rtl/data_memory_split.sv
// Byte-addressed little-endian data memory for the memory stage, with a
// two-cycle split access for halfwords/words that straddle a word boundary.

package data_memory_split_pkg;

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    BRANCH = 3'd3,
    JUMP   = 3'd4
  } InstructionTypes;

  typedef enum logic [3:0] {
    LOAD_BYTE  = 4'd0,
    LOAD_HALF  = 4'd1,
    LOAD_WORD  = 4'd2,
    ULOAD_BYTE = 4'd3,
    ULOAD_HALF = 4'd4,
    STORE_BYTE = 4'd5,
    STORE_HALF = 4'd6,
    STORE_WORD = 4'd7
  } InstructionSubTypes;

endpackage

module data_memory_split
  import data_memory_split_pkg::*;
#(
  parameter int unsigned WORD_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter string       INIT_FILE       = ""
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iReqValid,
  input  InstructionTypes    iInstructionType,
  input  InstructionSubTypes iMemoryInstructionType,
  input  logic [31:0]        iAddress,
  input  logic [31:0]        iMemData,
  output logic [31:0]        oMemData,
  output logic               oDataValid,
  output logic               oStall,
  output logic               oAccessFault
);

  localparam int unsigned AW    = WORD_ADDR_WIDTH;
  localparam int unsigned DEPTH = 2 ** AW;

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("data_memory_split: DATA_WIDTH must be 32");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  logic [31:0] mem [DEPTH];

  // Access size in bytes; unknown sub-types are word accesses
  function automatic logic [2:0] size_of(input InstructionSubTypes s);
    case (s)
      LOAD_BYTE, ULOAD_BYTE, STORE_BYTE: size_of = 3'd1;
      LOAD_HALF, ULOAD_HALF, STORE_HALF: size_of = 3'd2;
      default:                           size_of = 3'd4;
    endcase
  endfunction

  // Sign/zero extension of a right-aligned load result
  function automatic logic [31:0] extend(input InstructionSubTypes s, input logic [31:0] raw);
    case (s)
      LOAD_BYTE:  extend = {{24{raw[7]}}, raw[7:0]};
      ULOAD_BYTE: extend = {24'd0, raw[7:0]};
      LOAD_HALF:  extend = {{16{raw[15]}}, raw[15:0]};
      ULOAD_HALF: extend = {16'd0, raw[15:0]};
      default:    extend = raw;
    endcase
  endfunction

  state_t             state, next_state;
  logic [31:0]        mem_data, next_mem_data;
  logic               data_valid, next_valid;
  logic               stall, next_stall;
  logic               fault, next_fault;

  logic [AW-1:0]      lat_widx;
  logic [1:0]         lat_off;
  InstructionSubTypes lat_sub;
  logic               lat_store;
  logic [3:0]         lat_hi_be;
  logic [31:0]        lat_hi_data;
  logic [31:0]        lat_low;
  logic               latch;

  logic [3:0]         we;
  logic [AW-1:0]      waddr;
  logic [31:0]        wdata;

  // Request decode: size, alignment, byte lanes across the low/high word pair
  logic [2:0]    req_size;
  logic [1:0]    req_off;
  logic [AW-1:0] req_widx;
  logic          req_load, req_store, req_split, req_fault;
  logic [3:0]    size_mask;
  logic [7:0]    mask8;
  logic [63:0]   d64;
  logic [31:0]   rd_word;
  logic [AW-1:0] hi_widx;
  logic [31:0]   split_raw;

  assign req_size  = size_of(iMemoryInstructionType);
  assign req_off   = iAddress[1:0];
  assign req_widx  = iAddress[AW+1:2];
  assign req_load  = (iInstructionType == LOAD);
  assign req_store = (iInstructionType == STORE);
  assign req_split = ({1'b0, req_off} + req_size) > 3'd4;
  assign req_fault = (|iAddress[31:AW+2]) || (req_split && (req_widx == {AW{1'b1}}));
  assign size_mask = (req_size == 3'd1) ? 4'h1 : (req_size == 3'd2) ? 4'h3 : 4'hF;
  assign mask8     = {4'd0, size_mask} << req_off;
  assign d64       = {32'd0, iMemData} << {req_off, 3'b000};
  assign rd_word   = mem[req_widx];
  assign hi_widx   = AW'(lat_widx + 1'b1);
  assign split_raw = 32'({mem[hi_widx], lat_low} >> {lat_off, 3'b000});

  // Next-state, write port and output next-values
  always_comb begin
    next_state    = state;
    next_mem_data = mem_data;
    next_valid    = 1'b0;
    next_stall    = 1'b0;
    next_fault    = 1'b0;
    latch         = 1'b0;
    we            = 4'd0;
    waddr         = req_widx;
    wdata         = d64[31:0];
    case (state)
      IDLE: begin
        if (iReqValid && (req_load || req_store)) begin
          if (req_fault) begin
            next_fault = 1'b1;
            if (req_load) begin
              next_mem_data = 32'd0;
              next_valid    = 1'b1;
            end
          end else begin
            if (req_store) we = mask8[3:0];
            if (req_split) begin
              next_state = SECOND;
              next_stall = 1'b1;
              latch      = 1'b1;
            end else if (req_load) begin
              next_mem_data = extend(iMemoryInstructionType, rd_word >> {req_off, 3'b000});
              next_valid    = 1'b1;
            end
          end
        end
      end
      SECOND: begin
        next_state = IDLE;
        if (lat_store) begin
          we    = lat_hi_be;
          waddr = hi_widx;
          wdata = lat_hi_data;
        end else begin
          next_mem_data = extend(lat_sub, split_raw);
          next_valid    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (iRst) we = 4'd0;
  end

  // State, output and split-context registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      mem_data    <= 32'd0;
      data_valid  <= 1'b0;
      stall       <= 1'b0;
      fault       <= 1'b0;
      lat_widx    <= '0;
      lat_off     <= 2'd0;
      lat_sub     <= LOAD_WORD;
      lat_store   <= 1'b0;
      lat_hi_be   <= 4'd0;
      lat_hi_data <= 32'd0;
      lat_low     <= 32'd0;
    end else begin
      state      <= next_state;
      mem_data   <= next_mem_data;
      data_valid <= next_valid;
      stall      <= next_stall;
      fault      <= next_fault;
      if (latch) begin
        lat_widx    <= req_widx;
        lat_off     <= req_off;
        lat_sub     <= iMemoryInstructionType;
        lat_store   <= req_store;
        lat_hi_be   <= mask8[7:4];
        lat_hi_data <= d64[63:32];
        lat_low     <= rd_word;
      end
    end
  end

  // Byte-lane memory write; contents survive reset
  always_ff @(posedge iClk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign oMemData     = mem_data;
  assign oDataValid   = data_valid;
  assign oStall       = stall;
  assign oAccessFault = fault;

endmodule
